// File: rtl/pi_mem_bridge.sv
// Bridges SPI-domain byte access strobes into clk-domain req/ack memory transactions.
// One transaction per pi_act pulse. Read data is held on pi_dati until the next read completes.
module pi_mem_bridge #(
    parameter int TOUT_CYC = 32,
    parameter int SYNC_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pi_act,
    input  logic        pi_oe,
    input  logic        pi_we,
    input  logic [31:0] pi_addr,
    input  logic [7:0]  pi_dato,
    output logic [7:0]  pi_dati,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_dst,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_dato,
    input  logic        mem_ack,
    input  logic [7:0]  mem_dati,
    output logic        tout_err,
    output logic [7:0]  ovr_ctr
);

    localparam int CW = (TOUT_CYC > 1) ? $clog2(TOUT_CYC) : 1;
    localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [SYNC_LEN-1:0] act_sync_q;
    logic                act_d_q;
    logic [CW-1:0]       tout_cnt_q;
    logic                ovr_seen_q;
    logic [7:0]          pi_dati_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [1:0]          mem_dst_q;
    logic [22:0]         mem_addr_q;
    logic [7:0]          mem_dato_q;
    logic                tout_err_q;
    logic [7:0]          ovr_ctr_q;

    logic act_s;
    logic act_rise;
    logic req_ok_d;
    logic unused_addr_hi;

    assign act_s    = act_sync_q[SYNC_LEN-1];
    assign act_rise = act_s & ~act_d_q;
    // Only a single-direction command to PRG/CHR/SRM becomes an arbiter request.
    assign req_ok_d = (pi_oe ^ pi_we) && (pi_addr[24:23] != 2'd3);
    assign unused_addr_hi = ^pi_addr[31:25];

    // NOTE: every register here is clocked state, so it is written only with <=;
    // blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_sync_q <= '0;
            act_d_q    <= 1'b0;
        end else begin
            act_sync_q <= {act_sync_q[SYNC_LEN-2:0], pi_act};
            act_d_q    <= act_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tout_cnt_q <= '0;
            ovr_seen_q <= 1'b0;
            pi_dati_q  <= 8'hFF;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_dst_q  <= 2'd0;
            mem_addr_q <= 23'd0;
            mem_dato_q <= 8'd0;
            tout_err_q <= 1'b0;
            ovr_ctr_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (act_rise) begin
                        if (req_ok_d) begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= pi_we;
                            mem_dst_q  <= pi_addr[24:23];
                            mem_addr_q <= pi_addr[22:0];
                            mem_dato_q <= pi_dato;
                            tout_cnt_q <= '0;
                            ovr_seen_q <= 1'b0;
                            state_q    <= S_REQ;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    // The strobe dropping early is counted once, but the access still finishes.
                    if (!act_s && !ovr_seen_q) begin
                        ovr_seen_q <= 1'b1;
                        if (ovr_ctr_q != 8'hFF) begin
                            ovr_ctr_q <= ovr_ctr_q + 8'd1;
                        end
                    end
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            pi_dati_q <= mem_dati;
                        end
                        state_q <= S_DONE;
                    end else if (tout_cnt_q == TOUT_LAST) begin
                        mem_req_q  <= 1'b0;
                        tout_err_q <= 1'b1;
                        if (!mem_we_q) begin
                            pi_dati_q <= 8'hFF;
                        end
                        state_q <= S_DONE;
                    end else begin
                        tout_cnt_q <= tout_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!act_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pi_dati  = pi_dati_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_dst  = mem_dst_q;
    assign mem_addr = mem_addr_q;
    assign mem_dato = mem_dato_q;
    assign tout_err = tout_err_q;
    assign ovr_ctr  = ovr_ctr_q;

endmodule

// File: tb/tb_pi_mem_bridge.sv
// Directed bench for pi_mem_bridge: vector table for single accesses plus
// hand-written sequences for timeout, overrun saturation and mid-request reset.
module tb_pi_mem_bridge;

    localparam int SYNC_LEN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pi_act = 1'b0;
    logic        pi_oe = 1'b0;
    logic        pi_we = 1'b0;
    logic [31:0] pi_addr = '0;
    logic [7:0]  pi_dato = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_dati = '0;

    logic [7:0]  pi_dati, mem_dato, ovr_ctr;
    logic        mem_req, mem_we, tout_err;
    logic [1:0]  mem_dst;
    logic [22:0] mem_addr;

    logic [7:0]  dati64, dato64, ovr64;
    logic        req64, we64, tout64;
    logic [1:0]  dst64;
    logic [22:0] addr64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pi_mem_bridge #(.TOUT_CYC(32), .SYNC_LEN(SYNC_LEN)) u_dut (
        .clk(clk), .rst(rst), .pi_act(pi_act), .pi_oe(pi_oe), .pi_we(pi_we),
        .pi_addr(pi_addr), .pi_dato(pi_dato), .pi_dati(pi_dati),
        .mem_req(mem_req), .mem_we(mem_we), .mem_dst(mem_dst), .mem_addr(mem_addr),
        .mem_dato(mem_dato), .mem_ack(mem_ack), .mem_dati(mem_dati),
        .tout_err(tout_err), .ovr_ctr(ovr_ctr)
    );

    pi_mem_bridge #(.TOUT_CYC(64), .SYNC_LEN(SYNC_LEN)) u_dut64 (
        .clk(clk), .rst(rst), .pi_act(pi_act), .pi_oe(pi_oe), .pi_we(pi_we),
        .pi_addr(pi_addr), .pi_dato(pi_dato), .pi_dati(dati64),
        .mem_req(req64), .mem_we(we64), .mem_dst(dst64), .mem_addr(addr64),
        .mem_dato(dato64), .mem_ack(mem_ack), .mem_dati(mem_dati),
        .tout_err(tout64), .ovr_ctr(ovr64)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    typedef struct {
        string       name;
        logic        oe;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  dato;
        int          ack_dly;
        logic [7:0]  ack_data;
        logic        exp_req;
        logic        exp_we;
        logic [1:0]  exp_dst;
        logic [22:0] exp_addr;
        logic [7:0]  exp_dato;
        logic [7:0]  exp_dati;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        logic got_req;
        @(posedge clk); #1;
        pi_oe = v.oe; pi_we = v.we; pi_addr = v.addr; pi_dato = v.dato; pi_act = 1'b1;
        got_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                got_req = 1'b1;
                break;
            end
        end
        check({v.name, "_req"}, 32'(got_req), 32'(v.exp_req));
        if (got_req) begin
            check({v.name, "_we"}, 32'(mem_we), 32'(v.exp_we));
            check({v.name, "_dst"}, 32'(mem_dst), 32'(v.exp_dst));
            check({v.name, "_addr"}, 32'(mem_addr), 32'(v.exp_addr));
            check({v.name, "_dato"}, 32'(mem_dato), 32'(v.exp_dato));
            for (int d = 0; d < v.ack_dly; d++) begin
                @(posedge clk); #1;
            end
            check({v.name, "_req_held"}, 32'(mem_req), 32'd1);
            mem_ack = 1'b1; mem_dati = v.ack_data;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            check({v.name, "_req_drop"}, 32'(mem_req), 32'd0);
        end
        check({v.name, "_dati"}, 32'(pi_dati), 32'(v.exp_dati));
        check({v.name, "_st_done"}, 32'(int'(u_dut.state_q)), 32'd2);
        pi_act = 1'b0;
        repeat (SYNC_LEN + 3) @(posedge clk);
        #1;
        check({v.name, "_st_idle"}, 32'(int'(u_dut.state_q)), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int  req_cycles;
        logic got;

        vecs[0] = '{"rd_prg",  1'b1, 1'b0, 32'h0000_0123, 8'h00, 3, 8'h5A, 1'b1, 1'b0, 2'd0, 23'h000123, 8'h00, 8'h5A};
        vecs[1] = '{"wr_srm",  1'b0, 1'b1, 32'h0100_0005, 8'hC3, 1, 8'h77, 1'b1, 1'b1, 2'd2, 23'h000005, 8'hC3, 8'h5A};
        vecs[2] = '{"sys",     1'b1, 1'b0, 32'h0180_0020, 8'h00, 0, 8'h00, 1'b0, 1'b0, 2'd0, 23'h000000, 8'h00, 8'h5A};
        vecs[3] = '{"rd_chr",  1'b1, 1'b0, 32'h0081_2345, 8'h12, 0, 8'h3C, 1'b1, 1'b0, 2'd1, 23'h012345, 8'h12, 8'h3C};
        vecs[4] = '{"oe_we",   1'b1, 1'b1, 32'h0000_0040, 8'h00, 0, 8'h00, 1'b0, 1'b0, 2'd0, 23'h000000, 8'h00, 8'h3C};
        vecs[5] = '{"wr_chr",  1'b0, 1'b1, 32'h00FF_FFFF, 8'hA5, 5, 8'hEE, 1'b1, 1'b1, 2'd1, 23'h7FFFFF, 8'hA5, 8'h3C};
        vecs[6] = '{"rd_hi",   1'b1, 1'b0, 32'hFE00_0010, 8'h00, 2, 8'h81, 1'b1, 1'b0, 2'd0, 23'h000010, 8'h00, 8'h81};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_dati", 32'(pi_dati), 32'hFF);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_tout", 32'(tout_err), 32'd0);
        check("rst_ovr", 32'(ovr_ctr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k]);
        end

        // Ack outside REQ must be ignored
        mem_ack = 1'b1; mem_dati = 8'h11;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        check("stray_ack_dati", 32'(pi_dati), 32'h81);

        // Timeout: read with no ack
        pi_oe = 1'b1; pi_we = 1'b0; pi_addr = 32'h0000_0042; pi_act = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                got = 1'b1;
                break;
            end
        end
        check("tout_req_seen", 32'(got), 32'd1);
        req_cycles = got ? 1 : 0;
        for (int i = 0; i < 100 && got; i++) begin
            @(posedge clk); #1;
            if (!mem_req) break;
            req_cycles++;
        end
        check("tout_req_cycles", 32'(req_cycles), 32'd32);
        check("tout_err", 32'(tout_err), 32'd1);
        check("tout_dati", 32'(pi_dati), 32'hFF);
        pi_act = 1'b0;
        repeat (SYNC_LEN + 3) @(posedge clk);

        // Overrun counting and saturation (TOUT_CYC=64 instance)
        do_reset();
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            pi_oe = 1'b1; pi_we = 1'b0; pi_addr = 32'h0000_0010; pi_act = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (req64) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                check("ovr_req_seen", 32'(got), 32'd1);
                break;
            end
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (i == 10) pi_act = 1'b0;
            end
            mem_ack = 1'b1; mem_dati = (n == 0) ? 8'h99 : 8'(n);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (n == 0) begin
                check("ovr_first_cnt", 32'(ovr64), 32'd1);
                check("ovr_first_dati", 32'(dati64), 32'h99);
                check("ovr_first_req_drop", 32'(req64), 32'd0);
            end
            if (n == 254) check("ovr_reach_255", 32'(ovr64), 32'd255);
            repeat (SYNC_LEN + 3) @(posedge clk);
        end
        check("ovr_saturated", 32'(ovr64), 32'd255);
        check("ovr_no_tout", 32'(tout64), 32'd0);

        // Reset asserted mid-REQ
        do_reset();
        pi_oe = 1'b1; pi_we = 1'b0; pi_addr = 32'h0000_0077; pi_act = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                got = 1'b1;
                break;
            end
        end
        check("midrst_req_seen", 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_dati", 32'(pi_dati), 32'hFF);
        pi_act = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
